// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one active-low chip select.
// A start_tx pulse runs one full-duplex frame; tx_done pulses with the received byte on rx_data.
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_tx,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_done,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [DIV_W-1:0]      div_r, div_s;
  logic [BIT_W-1:0]      bit_r, bit_s;
  logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s;
  logic [DATA_WIDTH-1:0] rx_sh_r, rx_sh_s;
  logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
  logic                  cs_r, cs_s;
  logic                  sclk_r, sclk_s;
  logic                  mosi_r, mosi_s;
  logic                  busy_r, busy_s;
  logic                  done_r, done_s;
  logic                  tick_s;

  assign tick_s  = (div_r == DIV_LAST);
  assign tx_done = done_r;
  assign rx_data = rx_data_r;
  assign busy    = busy_r;
  assign spi_clk = sclk_r;
  assign mosi    = mosi_r;
  assign cs      = cs_r;

  // Next-state and next-output logic; every half-period tick advances the frame.
  always_comb begin
    state_s   = state_r;
    div_s     = div_r;
    bit_s     = bit_r;
    tx_sh_s   = tx_sh_r;
    rx_sh_s   = rx_sh_r;
    rx_data_s = rx_data_r;
    cs_s      = cs_r;
    sclk_s    = sclk_r;
    mosi_s    = mosi_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    case (state_r)
      IDLE: begin
        div_s = '0;
        bit_s = '0;
        if (start_tx) begin
          tx_sh_s = tx_data;
          mosi_s  = tx_data[DATA_WIDTH-1];
          cs_s    = 1'b0;
          busy_s  = 1'b1;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (tick_s) begin
          div_s   = '0;
          sclk_s  = 1'b1;
          rx_sh_s = {rx_sh_r[DATA_WIDTH-2:0], miso};
          state_s = SHIFT;
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      SHIFT: begin
        if (tick_s) begin
          div_s = '0;
          if (sclk_r) begin
            sclk_s = 1'b0;
            // After the last bit mosi keeps its value until cs rises.
            if (bit_r == BIT_LAST) begin
              state_s = HOLD;
            end else begin
              bit_s   = bit_r + 1'b1;
              tx_sh_s = {tx_sh_r[DATA_WIDTH-2:0], 1'b0};
              mosi_s  = tx_sh_r[DATA_WIDTH-2];
            end
          end else begin
            sclk_s  = 1'b1;
            rx_sh_s = {rx_sh_r[DATA_WIDTH-2:0], miso};
          end
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      HOLD: begin
        if (tick_s) begin
          div_s     = '0;
          bit_s     = '0;
          cs_s      = 1'b1;
          mosi_s    = 1'b0;
          busy_s    = 1'b0;
          done_s    = 1'b1;
          rx_data_s = rx_sh_r;
          state_s   = IDLE;
        end else begin
          div_s = div_r + 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        div_s   = '0;
        bit_s   = '0;
        cs_s    = 1'b1;
        sclk_s  = 1'b0;
        mosi_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      div_r     <= '0;
      bit_r     <= '0;
      tx_sh_r   <= '0;
      rx_sh_r   <= '0;
      rx_data_r <= '0;
      cs_r      <= 1'b1;
      sclk_r    <= 1'b0;
      mosi_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      div_r     <= div_s;
      bit_r     <= bit_s;
      tx_sh_r   <= tx_sh_s;
      rx_sh_r   <= rx_sh_s;
      rx_data_r <= rx_data_s;
      cs_r      <= cs_s;
      sclk_r    <= sclk_s;
      mosi_r    <= mosi_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: stimulus pushes expected frames, a monitor
// checks each tx_done against the queue plus frame timing and the mosi bit stream.
module tb_spi_master;

  localparam int DW        = 8;
  localparam int DIV       = 4;
  localparam int FRAME_CYC = (2 * DW + 1) * DIV;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          start_tx = 1'b0;
  logic [DW-1:0] tx_data  = 8'h00;
  logic          tx_done, busy, spi_clk, mosi, miso, cs;
  logic [DW-1:0] rx_data;

  spi_master #(.DATA_WIDTH(DW), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start_tx(start_tx), .tx_data(tx_data),
    .tx_done(tx_done), .rx_data(rx_data), .busy(busy), .spi_clk(spi_clk),
    .mosi(mosi), .miso(miso), .cs(cs)
  );

  always #5 clk = ~clk;

  // Slave model: loopback, or shifts slave_byte out MSB first, changing on falling edges.
  logic       loop_mode  = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  logic [2:0] slave_idx  = 3'd0;
  assign miso = loop_mode ? mosi : slave_byte[3'd7 - slave_idx];
  always @(negedge spi_clk or posedge cs) begin
    if (cs) slave_idx <= 3'd0;
    else if (slave_idx != 3'd7) slave_idx <= slave_idx + 3'd1;
  end

  typedef struct packed { logic [7:0] tx; logic [7:0] rx; } exp_t;
  exp_t sb_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0, fall_cyc = 0, last_done_cyc = 0, last_gap = 0, rises = 0, done_cnt = 0;
  logic [7:0] mosi_bits = 8'h00;
  logic clk_bad = 1'b0, prev_cs = 1'b1, prev_clk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks each frame and scores it against the queue on tx_done.
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (reset) begin
      rises    = 0;
      clk_bad  = 1'b0;
      prev_cs  = 1'b1;
      prev_clk = 1'b0;
    end else begin
      if (prev_cs && !cs) begin
        fall_cyc  = cyc;
        last_gap  = cyc - last_done_cyc;
        rises     = 0;
        mosi_bits = 8'h00;
        clk_bad   = 1'b0;
      end
      if (cs && spi_clk) clk_bad = 1'b1;
      if (!prev_clk && spi_clk) begin
        rises++;
        mosi_bits = {mosi_bits[6:0], mosi};
      end
      if (tx_done) begin
        done_cnt++;
        last_done_cyc = cyc;
        check("tx_done_expected", (sb_q.size() > 0) ? 1 : 0, 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("mosi_bits", mosi_bits, e.tx);
          check("spi_clk_rises", rises, DW);
          check("frame_cycles", cyc - fall_cyc, FRAME_CYC);
          check("spi_clk_while_cs_high", clk_bad, 0);
          check("end_cs_busy_mosi", {cs, busy, mosi}, 3'b100);
        end
      end
      prev_cs  = cs;
      prev_clk = spi_clk;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [7:0] d);
    tx_data  = d;
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    check("accept_cs_busy", {cs, busy}, 2'b01);
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 300) begin
      step();
      n++;
    end
    check("tx_done_count", done_cnt, target);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    step(3);
    check("rst_cs", cs, 1);
    check("rst_spi_clk", spi_clk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_rx_data", rx_data, 0);
    reset = 1'b0;
    step(2);

    // Loopback A5
    loop_mode = 1'b1;
    sb_q.push_back({8'hA5, 8'hA5});
    start(8'hA5);
    wait_done(1);

    // Send 3C while the slave returns C3
    step(2);
    loop_mode  = 1'b0;
    slave_byte = 8'hC3;
    sb_q.push_back({8'h3C, 8'hC3});
    start(8'h3C);
    wait_done(2);

    // Second request mid-frame is ignored, as is the tx_data change
    step(2);
    loop_mode = 1'b1;
    sb_q.push_back({8'h5A, 8'h5A});
    start(8'h5A);
    step(18);
    tx_data  = 8'hFF;
    start_tx = 1'b1;
    step();
    start_tx = 1'b0;
    check("busy_mid_frame", busy, 1);
    wait_done(3);
    step(80);
    check("no_extra_done", done_cnt, 3);

    // Reset mid-frame aborts without tx_done
    start(8'h96);
    step(28);
    reset = 1'b1;
    step();
    check("abort_cs", cs, 1);
    check("abort_spi_clk", spi_clk, 0);
    check("abort_busy", busy, 0);
    check("abort_tx_done", tx_done, 0);
    check("abort_rx_data", rx_data, 0);
    reset = 1'b0;
    step(100);
    check("abort_no_done", done_cnt, 3);
    sb_q.push_back({8'h69, 8'h69});
    start(8'h69);
    wait_done(4);

    // start_tx held high: back-to-back frames
    step(2);
    sb_q.push_back({8'h81, 8'h81});
    sb_q.push_back({8'h81, 8'h81});
    tx_data  = 8'h81;
    start_tx = 1'b1;
    n = 0;
    while (done_cnt < 6 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    start_tx = 1'b0;
    check("b2b_done_count", done_cnt, 6);
    check("b2b_cs_gap", last_gap, 1);
    step(80);
    check("b2b_no_extra_done", done_cnt, 6);
    check("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
